// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with per-tenure round-robin grant and an ack watchdog.
// Ports: i_clk/i_reset, master 0/1 buses (i_mx_*, o_mx_*), slave bus (o_wb_*, i_wb_*), o_grant, o_timeout.
module wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_m0_adr,
  input  logic [DATA_WIDTH-1:0] i_m0_dat,
  output logic [DATA_WIDTH-1:0] o_m0_dat,
  input  logic                  i_m0_we,
  input  logic [SEL_WIDTH-1:0]  i_m0_sel,
  input  logic                  i_m0_stb,
  input  logic                  i_m0_cyc,
  output logic                  o_m0_ack,
  output logic                  o_m0_err,
  input  logic [ADDR_WIDTH-1:0] i_m1_adr,
  input  logic [DATA_WIDTH-1:0] i_m1_dat,
  output logic [DATA_WIDTH-1:0] o_m1_dat,
  input  logic                  i_m1_we,
  input  logic [SEL_WIDTH-1:0]  i_m1_sel,
  input  logic                  i_m1_stb,
  input  logic                  i_m1_cyc,
  output logic                  o_m1_ack,
  output logic                  o_m1_err,
  output logic [ADDR_WIDTH-1:0] o_wb_adr,
  output logic [DATA_WIDTH-1:0] o_wb_dat,
  output logic                  o_wb_we,
  output logic [SEL_WIDTH-1:0]  o_wb_sel,
  output logic                  o_wb_stb,
  output logic                  o_wb_cyc,
  input  logic [DATA_WIDTH-1:0] i_wb_dat,
  input  logic                  i_wb_ack,
  output logic [1:0]            o_grant,
  output logic                  o_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic own0, own1;
  logic own_stb;
  logic abort;

  assign own0 = (state_q == OWN_M0);
  assign own1 = (state_q == OWN_M1);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; last_q == 1 means master 0 wins a tie
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc)
          state_d = last_q ? OWN_M0 : OWN_M1;
        else if (i_m0_cyc)
          state_d = OWN_M0;
        else if (i_m1_cyc)
          state_d = OWN_M1;
      end
      OWN_M0: begin
        if (!i_m0_cyc) begin
          state_d = i_m1_cyc ? OWN_M1 : IDLE;
          last_d  = 1'b0;
        end
      end
      OWN_M1: begin
        if (!i_m1_cyc) begin
          state_d = i_m0_cyc ? OWN_M0 : IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog: counts unacknowledged strobe cycles of the current owner
  assign own_stb = (own0 && i_m0_stb) || (own1 && i_m1_stb);
  assign abort   = own_stb && !i_wb_ack
                && (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!own_stb || i_wb_ack || abort
        || (state_d != state_q))
      cnt_d = '0;
  end

  // Output logic: slave-side mux and return path
  always_comb begin
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_we  = 1'b0;
    o_wb_sel = '0;
    o_wb_stb = 1'b0;
    o_wb_cyc = 1'b0;
    o_grant  = 2'b00;
    unique case (1'b1)
      own0: begin
        o_wb_adr = i_m0_adr;
        o_wb_dat = i_m0_dat;
        o_wb_we  = i_m0_we;
        o_wb_sel = i_m0_sel;
        o_wb_stb = i_m0_stb;
        o_wb_cyc = i_m0_cyc;
        o_grant  = 2'b01;
      end
      own1: begin
        o_wb_adr = i_m1_adr;
        o_wb_dat = i_m1_dat;
        o_wb_we  = i_m1_we;
        o_wb_sel = i_m1_sel;
        o_wb_stb = i_m1_stb;
        o_wb_cyc = i_m1_cyc;
        o_grant  = 2'b10;
      end
      default: ;
    endcase
  end

  assign o_m0_dat  = own0 ? i_wb_dat : '0;
  assign o_m1_dat  = own1 ? i_wb_dat : '0;
  assign o_m0_ack  = i_wb_ack && own0 && i_m0_stb && !abort;
  assign o_m1_ack  = i_wb_ack && own1 && i_m1_stb && !abort;
  assign o_m0_err  = abort && own0;
  assign o_m1_err  = abort && own1;
  assign o_timeout = abort;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: cycle-by-cycle vector table
// plus a long watchdog run checking abort pulse spacing.
module tb_wb_arbiter;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0004;
  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'h2222_0000;
  localparam logic [3:0]  S0 = 4'hF;
  localparam logic [3:0]  S1 = 4'h3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
  logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
  logic [31:0] wb_adr, wb_wdat, wb_rdat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;
  logic [1:0]  grant;
  logic        tmo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_adr(A0), .i_m0_dat(W0), .o_m0_dat(m0_rdat),
    .i_m0_we(m0_we), .i_m0_sel(S0), .i_m0_stb(m0_stb),
    .i_m0_cyc(m0_cyc), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_adr(A1), .i_m1_dat(W1), .o_m1_dat(m1_rdat),
    .i_m1_we(m1_we), .i_m1_sel(S1), .i_m1_stb(m1_stb),
    .i_m1_cyc(m1_cyc), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_wdat), .o_wb_we(wb_we),
    .o_wb_sel(wb_sel), .o_wb_stb(wb_stb), .o_wb_cyc(wb_cyc),
    .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack),
    .o_grant(grant), .o_timeout(tmo)
  );

  typedef struct {
    logic        rst;
    logic        c0, s0, we0;
    logic        c1, s1, we1;
    logic        ack;
    logic [31:0] rdat;
    logic [1:0]  g;
    logic        wcyc, wstb;
    logic        a0, a1, e0, e1, to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, c0, s0, we0, c1, s1, we1, ack,
    input logic [31:0] rd,
    input logic [1:0] g,
    input logic wc, ws, a0, a1, e0, e1, to);
    vec_t v;
    v.rst = r; v.c0 = c0; v.s0 = s0; v.we0 = we0;
    v.c1 = c1; v.s1 = s1; v.we1 = we1;
    v.ack = ack; v.rdat = rd; v.g = g;
    v.wcyc = wc; v.wstb = ws;
    v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1;
    v.to = to;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst;
    m0_cyc = v.c0; m0_stb = v.s0; m0_we = v.we0;
    m1_cyc = v.c1; m1_stb = v.s1; m1_we = v.we1;
    wb_ack = v.ack; wb_rdat = v.rdat;
  endtask

  task automatic check(input string nm, input vec_t v);
    logic [31:0] xadr, xwd, xd0, xd1;
    logic [3:0]  xsel;
    logic        xwe;
    logic [9:0]  act, exp;
    xadr = '0; xwd = '0; xsel = '0; xwe = 1'b0;
    xd0 = '0; xd1 = '0;
    if (v.g == 2'b01) begin
      xadr = A0; xwd = W0; xsel = S0; xwe = v.we0;
      xd0 = v.rdat;
    end else if (v.g == 2'b10) begin
      xadr = A1; xwd = W1; xsel = S1; xwe = v.we1;
      xd1 = v.rdat;
    end
    act = {grant, wb_cyc, wb_stb, m0_ack, m1_ack,
           m0_err, m1_err, tmo, wb_we};
    exp = {v.g, v.wcyc, v.wstb, v.a0, v.a1,
           v.e0, v.e1, v.to, xwe};
    checks++;
    if (act !== exp || wb_adr !== xadr || wb_wdat !== xwd
        || wb_sel !== xsel || m0_rdat !== xd0
        || m1_rdat !== xd1) begin
      failures++;
      $display("FAIL %s ctl=%b want %b adr=%h want %h d0=%h want %h d1=%h want %h",
               nm, act, exp, wb_adr, xadr, m0_rdat, xd0,
               m1_rdat, xd1);
    end
  endtask

  initial begin
    vec_t v;
    // r c0 s0 w0 c1 s1 w1 ack rdat | g cyc stb a0 a1 e0 e1 to
    // m0-only read
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0,0,0,2'b01,1,1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0,1,32'hCAFE_0001,2'b01,1,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,2'b01,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0));
    // reset, then alternation over four tenures
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1,1,0,0,0,2'b00,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1,1,0,1,32'hA,2'b01,1,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,0,0,2'b01,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,1,32'hB,2'b10,1,1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,2'b10,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1,1,0,0,0,2'b00,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1,1,0,1,32'hA,2'b01,1,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,0,0,2'b01,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,1,32'hB,2'b10,1,1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,2'b10,0,0,0,0,0,0,0));
    // tenure lock: three m0 writes while m1 waits
    tbl.push_back(mk(0,1,1,1,1,1,0,0,0,2'b00,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,1,1,0,1,0,2'b01,1,1,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,1,1,0,1,0,2'b01,1,1,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,1,1,0,1,0,2'b01,1,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,1,0,0,0,2'b01,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,1,32'h5,2'b10,1,1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,2'b10,0,0,0,0,0,0,0));
    // watchdog: abort in 5th stb cycle only
    tbl.push_back(mk(0,0,0,0,1,1,0,0,0,2'b00,0,0,0,0,0,0,0));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(mk(0,0,0,0,1,1,0,0,0,2'b10,1,1,0,0,
                       0,(k == 5),(k == 5)));
    tbl.push_back(mk(0,0,0,0,1,0,0,0,0,2'b10,1,0,0,0,0,0,0));
    // ack in the 5th cycle beats the abort
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(0,0,0,0,1,1,0,0,0,2'b10,1,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,1,32'hC,2'b10,1,1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,0,0,2'b10,1,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,2'b10,0,0,0,0,0,0,0));
    // reset mid-access, then ties
    tbl.push_back(mk(0,1,1,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0,0,0,2'b01,1,1,0,0,0,0,0));
    tbl.push_back(mk(1,1,1,0,0,0,0,0,0,2'b01,1,1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1,1,0,1,32'hD,2'b00,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1,1,0,1,32'hD,2'b01,1,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,2'b01,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1,1,0,0,0,2'b00,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1,1,0,1,32'hE,2'b10,1,1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,2'b10,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0));

    v = mk(1,0,0,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0);
    drive(v);
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("vec%0d", i), tbl[i]);
    end

    // Long stall: aborts every 5th cycle, one-cycle pulses
    @(negedge clk);
    v = mk(0,0,0,0,1,1,0,0,0,2'b00,0,0,0,0,0,0,0);
    drive(v);
    #1;
    check("wd_req", v);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      v = mk(0,0,0,0,1,1,0,0,0,2'b10,1,1,0,0,0,
             (k % 5 == 0),(k % 5 == 0));
      drive(v);
      #1;
      check($sformatf("wd_long%0d", k), v);
    end
    @(negedge clk);
    v = mk(0,0,0,0,0,0,0,0,0,2'b10,0,0,0,0,0,0,0);
    drive(v);
    #1;
    check("wd_rel", v);
    @(negedge clk);
    v = mk(0,0,0,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0);
    drive(v);
    #1;
    check("wd_idle", v);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
